// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core: parity modes, engine states,
// oversampling constants and the parity helper.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  // mode 2'b11 is reserved and behaves like "no parity"
  function automatic parity_e par_decode(input logic [1:0] m);
    case (m)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // parity bit that makes the count of ones over data+parity even (or odd)
  function automatic logic par_bit(input parity_e p, input logic [7:0] d);
    return (p == PAR_ODD) ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_core_param_if.sv
// CPU-side register/FIFO bus of the UART core; master = MMIO decoder side,
// slave = UART core.
interface uart_core_param_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0] baud_div;
  logic [1:0]       parity_mode;
  logic             tx_wen;
  logic [7:0]       tx_din;
  logic             tx_full;
  logic             tx_empty;
  logic             rx_ren;
  logic [7:0]       rx_dout;
  logic             rx_data_present;
  logic [CW-1:0]    rx_count;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;
  logic             err_clr;

  modport master (
    output baud_div, parity_mode, tx_wen, tx_din, rx_ren, err_clr,
    input  tx_full, tx_empty, rx_dout, rx_data_present, rx_count,
           frame_err, overrun, parity_err
  );

  modport slave (
    input  baud_div, parity_mode, tx_wen, tx_din, rx_ren, err_clr,
    output tx_full, tx_empty, rx_dout, rx_data_present, rx_count,
           frame_err, overrun, parity_err
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A pop on empty is ignored; a push on full lands only if a pop frees a slot that clk.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART: runtime 16x baud tick, RX/TX engines, RX/TX FWFT FIFOs, sticky errors.
// Define UART_PARITY_EN to add the parity state and honour parity_mode.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               rx,
  output logic               tx,
  uart_core_param_if.slave   bus
);
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int STOP_TICKS = OVERSAMPLE * STOP_BITS;

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt >= bus.baud_div);

  always_ff @(posedge clk) begin
    if (!Rst) tick_cnt <= '0;
    else      tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
  end

  // ---------------- TX ----------------
  logic [7:0]    tx_head;
  logic          txf_empty, txf_full, tx_pop, tx_bit_end, tx_r;
  logic [CW-1:0] unused_tx_cnt;
  uart_state_e   tx_st;
  logic [4:0]    tx_tc;
  logic [2:0]    tx_bi;
  logic [7:0]    tx_sh;
`ifdef UART_PARITY_EN
  parity_e       tx_pm;
  logic          tx_par;
`endif

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .Rst(Rst), .wr_en(bus.tx_wen), .din(bus.tx_din), .rd_en(tx_pop),
    .dout(tx_head), .empty(txf_empty), .full(txf_full), .count(unused_tx_cnt)
  );

  assign tx_bit_end = (tx_tc == ((tx_st == S_STOP) ? 5'(STOP_TICKS - 1) : 5'(OVERSAMPLE - 1)));
  // a new frame starts from IDLE or straight out of STOP, so there is no idle gap
  assign tx_pop = tick && !txf_empty &&
                  ((tx_st == S_IDLE) || (tx_st == S_STOP && tx_bit_end));

  always_ff @(posedge clk) begin
    if (!Rst) begin
      tx_st <= S_IDLE;
      tx_tc <= '0;
      tx_bi <= '0;
      tx_sh <= '0;
      tx_r  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_pm  <= PAR_NONE;
      tx_par <= 1'b0;
`endif
    end else if (tick) begin
      tx_tc <= (tx_st == S_IDLE || tx_bit_end) ? '0 : tx_tc + 5'd1;
      case (tx_st)
        S_START: if (tx_bit_end) begin
          tx_st <= S_DATA;
          tx_bi <= '0;
          tx_r  <= tx_sh[0];
        end
        S_DATA: if (tx_bit_end) begin
          tx_bi <= tx_bi + 3'd1;
          tx_sh <= {1'b0, tx_sh[7:1]};
          tx_r  <= tx_sh[1];
          if (tx_bi == 3'd7) begin
            tx_st <= S_STOP;
            tx_r  <= 1'b1;
`ifdef UART_PARITY_EN
            if (tx_pm != PAR_NONE) begin
              tx_st <= S_PARITY;
              tx_r  <= tx_par;
            end
`endif
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: if (tx_bit_end) begin
          tx_st <= S_STOP;
          tx_r  <= 1'b1;
        end
`endif
        S_STOP:  if (tx_bit_end) tx_st <= S_IDLE;
        default: tx_st <= S_IDLE;
      endcase
      if (tx_pop) begin
        tx_st <= S_START;
        tx_sh <= tx_head;
        tx_r  <= 1'b0;
`ifdef UART_PARITY_EN
        tx_pm  <= par_decode(bus.parity_mode);
        tx_par <= par_bit(par_decode(bus.parity_mode), tx_head);
`endif
      end
    end
  end

  assign tx           = tx_r;
  assign bus.tx_full  = txf_full;
  assign bus.tx_empty = txf_empty && (tx_st == S_IDLE);

  // ---------------- RX ----------------
  logic [1:0]  rx_sync;
  logic        rx_s, rx_d, rx_samp, rx_push, rxf_empty, rxf_full;
  uart_state_e rx_st;
  logic [3:0]  rx_tc;
  logic [2:0]  rx_bi;
  logic [7:0]  rx_sh;
  logic        fe_r, ov_r;
`ifdef UART_PARITY_EN
  parity_e     rx_pm;
  logic        pe_r;
`endif

  always_ff @(posedge clk) begin
    if (!Rst) begin
      rx_sync <= 2'b11;
      rx_d    <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_d    <= rx_sync[1];
    end
  end

  assign rx_s    = rx_sync[1];
  assign rx_samp = tick && (rx_st != S_IDLE) &&
                   (rx_tc == ((rx_st == S_START) ? 4'(MID_SAMPLE - 1) : 4'(OVERSAMPLE - 1)));
  assign rx_push = rx_samp && (rx_st == S_STOP) && rx_s;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .Rst(Rst), .wr_en(rx_push), .din(rx_sh), .rd_en(bus.rx_ren),
    .dout(bus.rx_dout), .empty(rxf_empty), .full(rxf_full), .count(bus.rx_count)
  );

  always_ff @(posedge clk) begin
    if (!Rst) begin
      rx_st <= S_IDLE;
      rx_tc <= '0;
      rx_bi <= '0;
      rx_sh <= '0;
`ifdef UART_PARITY_EN
      rx_pm <= PAR_NONE;
`endif
    end else begin
      case (rx_st)
        S_IDLE: if (rx_d && !rx_s) begin
          rx_st <= S_START;
          rx_tc <= '0;
`ifdef UART_PARITY_EN
          rx_pm <= par_decode(bus.parity_mode);
`endif
        end
        default: if (tick) begin
          rx_tc <= rx_samp ? '0 : rx_tc + 4'd1;
          if (rx_samp) begin
            case (rx_st)
              // a start bit that is high again at mid-bit was a glitch
              S_START: begin
                rx_bi <= '0;
                rx_st <= rx_s ? S_IDLE : S_DATA;
              end
              S_DATA: begin
                rx_sh <= {rx_s, rx_sh[7:1]};
                rx_bi <= rx_bi + 3'd1;
                if (rx_bi == 3'd7) begin
                  rx_st <= S_STOP;
`ifdef UART_PARITY_EN
                  if (rx_pm != PAR_NONE) rx_st <= S_PARITY;
`endif
                end
              end
`ifdef UART_PARITY_EN
              S_PARITY: rx_st <= S_STOP;
`endif
              default: rx_st <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // sticky errors; err_clr beats a set in the same clk
  always_ff @(posedge clk) begin
    if (!Rst || bus.err_clr) begin
      fe_r <= 1'b0;
      ov_r <= 1'b0;
`ifdef UART_PARITY_EN
      pe_r <= 1'b0;
`endif
    end else begin
      if (rx_samp && rx_st == S_STOP && !rx_s)   fe_r <= 1'b1;
      if (rx_push && rxf_full && !bus.rx_ren)    ov_r <= 1'b1;
`ifdef UART_PARITY_EN
      if (rx_samp && rx_st == S_PARITY && rx_s != par_bit(rx_pm, rx_sh)) pe_r <= 1'b1;
`endif
    end
  end

  assign bus.frame_err       = fe_r;
  assign bus.overrun         = ov_r;
  assign bus.rx_data_present = !rxf_empty;
`ifdef UART_PARITY_EN
  assign bus.parity_err = pe_r;
`else
  logic unused_pm;
  assign unused_pm      = ^bus.parity_mode;
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: reset values, TX waveform, loopback table,
// glitch/overrun/frame/reset corners, and randomized RX/TX against a queue model.
module tb_uart_core_param;
  localparam int DEPTH = 4;
  localparam int BC4   = 80;   // clk per bit at baud_div=4
  localparam int BC0   = 16;   // clk per bit at baud_div=0

  logic clk = 1'b0, Rst = 1'b0, rx_drv = 1'b1, loop = 1'b0;
  logic rx, tx;
  int   checks = 0, errors = 0;

  uart_core_param_if #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) bus ();
  assign rx = loop ? tx : rx_drv;

  uart_core_param #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .STOP_BITS(1)) dut (
    .clk(clk), .Rst(Rst), .rx(rx), .tx(tx), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    @(posedge clk); #1 bus.tx_wen = 1'b1; bus.tx_din = d;
    @(posedge clk); #1 bus.tx_wen = 1'b0;
  endtask

  task automatic pop_rx();
    @(posedge clk); #1 bus.rx_ren = 1'b1;
    @(posedge clk); #1 bus.rx_ren = 1'b0;
  endtask

  task automatic clr_err();
    @(posedge clk); #1 bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
  endtask

  // frame[0]=start, frame[8:1]=data, frame[9]=stop, each sampled at mid-bit
  task automatic tx_capture(input int bc, output logic [9:0] frame, output bit got);
    got = 1'b0; frame = '0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin got = 1'b1; break; end
    end
    if (!got) return;
    repeat (bc / 2) @(negedge clk);
    frame[0] = tx;
    for (int b = 1; b < 10; b++) begin
      repeat (bc) @(negedge clk);
      frame[b] = tx;
    end
  endtask

  // par<0 means no parity bit; one idle bit follows the frame
  task automatic rx_send(input logic [7:0] d, input int bc, input logic stop, input int par);
    logic [10:0] bits;
    int n;
    bits = '1; bits[0] = 1'b0; bits[8:1] = d; n = 9;
    if (par >= 0) begin bits[9] = par[0]; n = 10; end
    bits[n] = stop; n++;
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (bc) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (bc) @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int n, input int max, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (int'(bus.rx_count) == n) begin ok = 1'b1; break; end
    end
    if (!ok) chk({nm, "_timeout"}, int'(bus.rx_count), n);
  endtask

  typedef struct {
    logic [15:0] div;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    int          exp_cnt;
  } vec_t;

  initial begin
    vec_t        tbl[6];
    logic [9:0]  fr;
    bit          got;
    logic [7:0]  q[$];
    logic [9:0]  txq[$];
    logic [7:0]  d;
    logic        stop, exp_fe, exp_ov;

    tbl[0] = '{16'd4, 8'h55, 8'h55, 1};
    tbl[1] = '{16'd0, 8'h80, 8'h80, 1};
    tbl[2] = '{16'd1, 8'h01, 8'h01, 1};
    tbl[3] = '{16'd2, 8'hFE, 8'hFE, 1};
    tbl[4] = '{16'd0, 8'h00, 8'h00, 1};
    tbl[5] = '{16'd3, 8'hC7, 8'hC7, 1};

    bus.baud_div = 16'd4; bus.parity_mode = 2'b00; bus.tx_wen = 1'b0; bus.tx_din = '0;
    bus.rx_ren = 1'b0; bus.err_clr = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_tx_full", bus.tx_full, 0);
    chk("rst_tx_empty", bus.tx_empty, 1);
    chk("rst_rx_present", bus.rx_data_present, 0);
    chk("rst_rx_dout", bus.rx_dout, 0);
    chk("rst_rx_count", bus.rx_count, 0);
    chk("rst_errs", {bus.frame_err, bus.overrun, bus.parity_err}, 0);
    @(posedge clk); #1 Rst = 1'b1;

    // single TX frame 0xA5, 8N1
    push_tx(8'hA5);
    tx_capture(BC4, fr, got);
    chk("tx_a5_started", got, 1);
    chk("tx_a5_frame", fr, {1'b1, 8'hA5, 1'b0});
    repeat (50) @(negedge clk);
    chk("tx_a5_empty_after", bus.tx_empty, 1);
    chk("tx_a5_idle_high", tx, 1);

    // loopback table
    loop = 1'b1;
    foreach (tbl[i]) begin
      bus.baud_div = tbl[i].div;
      push_tx(tbl[i].din);
      wait_count(tbl[i].exp_cnt, 2000, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_dout", i), bus.rx_dout, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_cnt", i), bus.rx_count, tbl[i].exp_cnt);
      pop_rx();
      @(negedge clk);
      chk($sformatf("tbl%0d_cnt_after_pop", i), bus.rx_count, 0);
    end

    // three back-to-back frames through the loop
    bus.baud_div = 16'd4;
    push_tx(8'h00); push_tx(8'hFF); push_tx(8'h3C);
    wait_count(3, 4000, "loop3");
    chk("loop3_count", bus.rx_count, 3);
    foreach (tbl[i]) if (i < 3) begin
      chk($sformatf("loop3_pop%0d", i), bus.rx_dout, (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h3C);
      pop_rx();
    end
    @(negedge clk);
    chk("loop3_empty", bus.rx_data_present, 0);
    chk("loop3_flags", {bus.frame_err, bus.overrun, bus.parity_err}, 0);
    repeat (100) @(posedge clk);
    loop = 1'b0;

    // short low pulse is rejected as a glitch
    #1 rx_drv = 1'b0;
    repeat (30) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_count", bus.rx_count, 0);
    chk("glitch_fe", bus.frame_err, 0);

    // five frames, no pops: FIFO fills, fifth frame overruns
    for (int i = 1; i <= 5; i++) rx_send(8'(i * 8'h11), BC4, 1'b1, -1);
    @(negedge clk);
    chk("ovr_count", bus.rx_count, DEPTH);
    chk("ovr_flag", bus.overrun, 1);
    clr_err();
    @(negedge clk);
    chk("ovr_cleared", bus.overrun, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("ovr_pop%0d", i), bus.rx_dout, i * 8'h11);
      pop_rx();
    end
    @(negedge clk);
    chk("ovr_drained", bus.rx_count, 0);
    pop_rx();
    @(negedge clk);
    chk("pop_empty_ignored", bus.rx_count, 0);

    // stop bit low
    rx_send(8'h77, BC4, 1'b0, -1);
    @(negedge clk);
    chk("fe_flag", bus.frame_err, 1);
    chk("fe_count", bus.rx_count, 0);
    clr_err();
`ifdef UART_PARITY_EN
    bus.parity_mode = 2'b10;
    rx_send(8'h03, BC4, 1'b1, 0);
    @(negedge clk);
    chk("pe_flag", bus.parity_err, 1);
    chk("pe_count", bus.rx_count, 1);
    chk("pe_dout", bus.rx_dout, 8'h03);
    pop_rx();
    bus.parity_mode = 2'b00;
    clr_err();
`else
    @(negedge clk);
    chk("pe_tied_low", bus.parity_err, 0);
`endif

    // reset pulse mid-TX
    push_tx(8'hC3);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin got = 1'b1; break; end
    end
    chk("rstmid_started", got, 1);
    repeat (100) @(posedge clk);
    #1 Rst = 1'b0;
    @(posedge clk); #1 Rst = 1'b1;
    @(negedge clk);
    chk("rstmid_tx", tx, 1);
    chk("rstmid_tx_empty", bus.tx_empty, 1);
    chk("rstmid_rx_count", bus.rx_count, 0);
    push_tx(8'h5A);
    tx_capture(BC4, fr, got);
    chk("rstmid_next_frame", fr, {1'b1, 8'h5A, 1'b0});

    // randomized RX against a queue model
    bus.baud_div = 16'd0;
    repeat (100) @(posedge clk);
    clr_err();
    while (bus.rx_count != 0) pop_rx();
    exp_fe = 1'b0; exp_ov = 1'b0;
    for (int it = 0; it < 24; it++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      rx_send(d, BC0, stop, -1);
      if (!stop) exp_fe = 1'b1;
      else if (q.size() == DEPTH) exp_ov = 1'b1;
      else q.push_back(d);
      @(negedge clk);
      chk($sformatf("rnd%0d_count", it), bus.rx_count, q.size());
      chk($sformatf("rnd%0d_flags", it), {bus.frame_err, bus.overrun}, {exp_fe, exp_ov});
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        @(negedge clk);
        if (q.size() > 0) chk($sformatf("rnd%0d_dout", it), bus.rx_dout, q.pop_front());
        pop_rx();
      end
    end

    // fill the TX FIFO with the tick stalled, overflow it, then release
    bus.baud_div = 16'hFFFF;
    repeat (5) @(posedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      txq.push_back({1'b1, d, 1'b0});
      push_tx(d);
    end
    @(negedge clk);
    chk("txfill_full", bus.tx_full, 1);
    push_tx(8'hEE);
    @(negedge clk);
    chk("txfill_still_full", bus.tx_full, 1);
    chk("txfill_not_empty", bus.tx_empty, 0);
    bus.baud_div = 16'd0;
    while (txq.size() > 0) begin
      tx_capture(BC0, fr, got);
      chk("txfill_frame", fr, txq.pop_front());
    end
    repeat (40) @(negedge clk);
    chk("txfill_drop_empty", bus.tx_empty, 1);

    // randomized back-to-back TX bursts
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        d = 8'($urandom);
        txq.push_back({1'b1, d, 1'b0});
        push_tx(d);
      end
      while (txq.size() > 0) begin
        tx_capture(BC0, fr, got);
        chk($sformatf("txrnd%0d_frame", r), fr, txq.pop_front());
      end
      repeat (40) @(negedge clk);
      chk($sformatf("txrnd%0d_empty", r), bus.tx_empty, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
